counter_run_arbiter: RTL and testbench
======================================

// Module: counter_run_arbiter
// PURPOSE
//   Shares one WIDTH-bit up-counter datapath between two requesters.
//   Each requester asks for a "run" of LEN counts. The arbiter grants round-robin,
//   clears the counter, enables it until its output equals LEN, then pulses done.
//   It sits beside the counter and drives only its clear/enable. It reads back q.
// PARAMETERS
//   WIDTH  4  counter width; also the width of len0/len1/cnt_q
// PORTS
//   clk     in   1      system clock, rising-edge
//   reset   in   1      asynchronous, active-high reset
//   req0    in   1      requester 0 run request; held high until done0 or abort
//   len0    in   WIDTH  requester 0 run length, sampled at grant
//   req1    in   1      requester 1 run request
//   len1    in   WIDTH  requester 1 run length, sampled at grant
//   cnt_q   in   WIDTH  counter output; counter is synchronous, clears on cnt_clr, increments on cnt_en
//   gnt0    out  1      requester 0 owns the counter (registered)
//   gnt1    out  1      requester 1 owns the counter (registered)
//   done0   out  1      one-cycle pulse: requester 0 run complete (registered)
//   done1   out  1      one-cycle pulse: requester 1 run complete (registered)
//   cnt_clr out  1      counter synchronous clear (decoded from state)
//   cnt_en  out  1      counter count enable (combinational)
//   busy    out  1      state != IDLE
// BEHAVIOUR
//   Reset (async, immediate, no clock needed):
//     - state=IDLE; gnt*/done*/cnt_clr/cnt_en/busy=0; len_lat=0
//     - last_served=1, so req0 wins the first tie
//   FSM IDLE -> CLEAR -> RUN -> DONE -> IDLE. Each state lasts >=1 cycle.
//   IDLE:
//     - If any req: winner is the sole requester; on a tie, the one != last_served.
//     - Latch the winner's len into len_lat. Set its gnt at the edge. -> CLEAR.
//   CLEAR: cnt_clr=1 for exactly one cycle; cnt_en=0; -> RUN.
//   RUN:
//     - cnt_en = (cnt_q != len_lat). Counter steps 0,1,...,len_lat and stops there.
//     - When cnt_q == len_lat: cnt_en=0 the same cycle; -> DONE at the next edge.
//   DONE:
//     - done of the granted side=1 for one cycle; cnt_en=0.
//     - On exit: gnt cleared, last_served=granted side, -> IDLE.
//   Timing: gnt rises at edge E; done is high in the cycle after edge E+len+2; gnt falls at E+len+3.
//   len=0 is legal: CLEAR, then RUN for 1 cycle with en=0, then DONE.
//   Max len=2^WIDTH-1. The counter never wraps because en drops at equality.
//   len* changes while granted are ignored (latched value used).
//   Abort: granted req low in CLEAR or RUN -> next edge IDLE, gnt=0, no done pulse,
//     last_served still updated; cnt_en=0 in that cycle.
//   req asserted during DONE is seen only in IDLE, so there is >=1 IDLE cycle between runs.
//   At most one gnt and one done high at any time; gnt0&gnt1 never both 1.
// TESTING
//   1 assert reset mid-cycle with no clock -> all outputs 0 immediately; held at 0 while reset=1
//   2 req0=1,len0=5 -> gnt0 next edge; cnt_clr 1 cycle; cnt_en 5 cycles; q 0..5;
//     done0 pulse 7 edges after gnt0 rise; gnt0 low one edge later
//   3 req0,req1 both high from reset, len0=2,len1=3 -> gnt0 run first, then gnt1 run;
//     re-request both -> gnt0 again (alternation); grants never overlap
//   4 req1 len1=0 -> cnt_clr, cnt_en never high, done1 2 edges after gnt1
//   5 req0 len0=9, drop req0 when q=4 -> gnt0=0 next edge, no done0, q frozen at 4 or 5;
//     pending req1 granted in the following IDLE
//   6 req0 len0=15 (WIDTH=4) -> q reaches 15 and holds, no wrap to 0, done0 after 17 edges;
//     async reset during RUN -> gnt0/cnt_en drop at once

Source files
------------

// File: rtl/counter_run_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : counter_run_arbiter
// Purpose  : Round-robin owner of a shared up-counter. Clears it, enables it
//            until it reaches the requested length, then pulses done.
// Revision : 1.0  initial release
// ============================================================================
module counter_run_arbiter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0,
   input  logic [WIDTH-1:0] len0,
   input  logic             req1,
   input  logic [WIDTH-1:0] len1,
   input  logic [WIDTH-1:0] cnt_q,
   output logic             gnt0,
   output logic             gnt1,
   output logic             done0,
   output logic             done1,
   output logic             cnt_clr,
   output logic             cnt_en,
   output logic             busy
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_CLEAR = 2'd1;
   localparam logic [1:0] ST_RUN   = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   logic [1:0]       state_q, state_d;
   logic             gnt0_q, gnt0_d;
   logic             gnt1_q, gnt1_d;
   logic             done0_q, done0_d;
   logic             done1_q, done1_d;
   logic             last_q, last_d;
   logic [WIDTH-1:0] len_q, len_d;

   logic w_req_own;
   logic w_pick1;
   logic w_at_len;

   assign w_req_own = gnt1_q ? req1 : req0;
   // Tie goes to whichever side was not served last.
   assign w_pick1   = req1 & (~req0 | ~last_q);
   assign w_at_len  = (cnt_q == len_q);

   always_comb begin
      state_d = state_q;
      gnt0_d  = gnt0_q;
      gnt1_d  = gnt1_q;
      done0_d = 1'b0;
      done1_d = 1'b0;
      last_d  = last_q;
      len_d   = len_q;
      case (state_q)
         ST_IDLE: begin
            if (req0 || req1) begin
               gnt0_d  = ~w_pick1;
               gnt1_d  = w_pick1;
               len_d   = w_pick1 ? len1 : len0;
               state_d = ST_CLEAR;
            end
         end
         ST_CLEAR, ST_RUN: begin
            if (!w_req_own) begin
               gnt0_d  = 1'b0;
               gnt1_d  = 1'b0;
               last_d  = gnt1_q;
               state_d = ST_IDLE;
            end else if (state_q == ST_CLEAR) begin
               state_d = ST_RUN;
            end else if (w_at_len) begin
               done0_d = gnt0_q;
               done1_d = gnt1_q;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            gnt0_d  = 1'b0;
            gnt1_d  = 1'b0;
            last_d  = gnt1_q;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         gnt0_q  <= 1'b0;
         gnt1_q  <= 1'b0;
         done0_q <= 1'b0;
         done1_q <= 1'b0;
         last_q  <= 1'b1;
         len_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt0_q  <= gnt0_d;
         gnt1_q  <= gnt1_d;
         done0_q <= done0_d;
         done1_q <= done1_d;
         last_q  <= last_d;
         len_q   <= len_d;
      end
   end

   assign gnt0    = gnt0_q;
   assign gnt1    = gnt1_q;
   assign done0   = done0_q;
   assign done1   = done1_q;
   assign busy    = (state_q != ST_IDLE);
   assign cnt_clr = (state_q == ST_CLEAR);
   // Enable drops the same cycle the counter hits the target or the owner aborts.
   assign cnt_en  = (state_q == ST_RUN) & w_req_own & ~w_at_len;

endmodule
`default_nettype wire

// File: tb/tb_counter_run_arbiter.sv
`default_nettype none
// Testbench for counter_run_arbiter: timeline model plus directed run checks.
module tb_counter_run_arbiter;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       req0 = 1'b0, req1 = 1'b0;
   logic [3:0] len0 = 4'd0, len1 = 4'd0;
   logic [3:0] cnt_q;
   logic       gnt0, gnt1, done0, done1, cnt_clr, cnt_en, busy;

   int checks = 0;
   int errors = 0;

   counter_run_arbiter #(.WIDTH(4)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .len0(len0), .req1(req1), .len1(len1),
      .cnt_q(cnt_q),
      .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
      .cnt_clr(cnt_clr), .cnt_en(cnt_en), .busy(busy)
   );

   always #5 clk = ~clk;

   // The shared counter the arbiter controls
   always @(posedge clk or posedge reset) begin
      if (reset)        cnt_q <= 4'd0;
      else if (cnt_clr) cnt_q <= 4'd0;
      else if (cnt_en)  cnt_q <= cnt_q + 4'd1;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a run is a timeline of t = cycles since the grant edge.
   // t=0 clear, t=1..L counting, t=L+1 at target, t=L+2 done.
   bit m_act  = 1'b0;
   bit m_side = 1'b0;
   bit m_last = 1'b1;
   int m_t    = 0;
   int m_len  = 0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_act  <= 1'b0;
         m_last <= 1'b1;
         m_t    <= 0;
      end else if (m_act) begin
         if (m_t == m_len + 2) begin
            m_act  <= 1'b0;
            m_last <= m_side;
         end else if (!(m_side ? req1 : req0)) begin
            m_act  <= 1'b0;
            m_last <= m_side;
         end else begin
            m_t <= m_t + 1;
         end
      end else if (req0 || req1) begin
         m_side <= (req0 && req1) ? !m_last : req1;
         m_len  <= (req0 && req1) ? (m_last ? int'(len0) : int'(len1))
                                  : (req1 ? int'(len1) : int'(len0));
         m_t    <= 0;
         m_act  <= 1'b1;
      end
   end

   always @(negedge clk) begin
      bit own_req;
      own_req = m_side ? req1 : req0;
      chk("gnt0",    int'(gnt0),    int'(m_act && !m_side));
      chk("gnt1",    int'(gnt1),    int'(m_act && m_side));
      chk("done0",   int'(done0),   int'(m_act && !m_side && m_t == m_len + 2));
      chk("done1",   int'(done1),   int'(m_act && m_side && m_t == m_len + 2));
      chk("cnt_clr", int'(cnt_clr), int'(m_act && m_t == 0));
      chk("cnt_en",  int'(cnt_en),  int'(m_act && m_t >= 1 && m_t <= m_len && own_req));
      chk("busy",    int'(busy),    int'(m_act));
   end

   // Run observer: indices count negedges after the first edge of the window.
   int o_g0r, o_g1r, o_g0f, o_g1f, o_d0, o_d1, o_en, o_clr, o_qmax, o_qdone, o_ovl;

   task automatic obs(input int n, input int abort_q);
      bit s_d0, s_d1, s_ab;
      o_g0r = -1; o_g1r = -1; o_g0f = -1; o_g1f = -1; o_d0 = -1; o_d1 = -1;
      o_en = 0; o_clr = 0; o_qmax = 0; o_qdone = -1; o_ovl = 0;
      @(posedge clk);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (gnt0 && o_g0r < 0) o_g0r = i;
         if (!gnt0 && o_g0r >= 0 && o_g0f < 0) o_g0f = i;
         if (gnt1 && o_g1r < 0) o_g1r = i;
         if (!gnt1 && o_g1r >= 0 && o_g1f < 0) o_g1f = i;
         if (done0 && o_d0 < 0) begin o_d0 = i; o_qdone = int'(cnt_q); end
         if (done1 && o_d1 < 0) o_d1 = i;
         if (cnt_en) o_en++;
         if (cnt_clr) o_clr++;
         if (int'(cnt_q) > o_qmax) o_qmax = int'(cnt_q);
         if (gnt0 && gnt1) o_ovl++;
         s_d0 = done0;
         s_d1 = done1;
         s_ab = (abort_q >= 0) && gnt0 && req0 && (int'(cnt_q) == abort_q);
         #2;
         if (s_d0) req0 = 1'b0;
         if (s_d1) req1 = 1'b0;
         if (s_ab) begin
            req0 = 1'b0;
            #1;
            chk("abort_en_low", int'(cnt_en), 0);
         end
      end
   endtask

   task automatic align();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset is applied before any clock edge
      #1;
      chk("rst_gnt0", int'(gnt0), 0);
      chk("rst_gnt1", int'(gnt1), 0);
      chk("rst_done", int'(done0 | done1), 0);
      chk("rst_clr",  int'(cnt_clr), 0);
      chk("rst_en",   int'(cnt_en), 0);
      chk("rst_busy", int'(busy), 0);
      // Both requesters already pending when reset releases
      req0 = 1'b1; len0 = 4'd2;
      req1 = 1'b1; len1 = 4'd3;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      obs(14, -1);
      chk("tie_g0_first", o_g0r, 0);
      chk("tie_d0",       o_d0, 4);
      chk("tie_g1_rise",  o_g1r, 6);
      chk("tie_d1",       o_d1, 11);
      chk("tie_overlap",  o_ovl, 0);

      align();
      req0 = 1'b1; req1 = 1'b1;
      obs(14, -1);
      chk("alt_g0_first", o_g0r, 0);
      chk("alt_g1_rise",  o_g1r, 6);
      chk("alt_overlap",  o_ovl, 0);

      align();
      req0 = 1'b1; len0 = 4'd5;
      obs(10, -1);
      chk("len5_g0_rise", o_g0r, 0);
      chk("len5_done0",   o_d0, 7);
      chk("len5_g0_fall", o_g0f, 8);
      chk("len5_en_cnt",  o_en, 5);
      chk("len5_clr_cnt", o_clr, 1);
      chk("len5_qmax",    o_qmax, 5);

      align();
      req1 = 1'b1; len1 = 4'd0;
      obs(6, -1);
      chk("len0_g1_rise", o_g1r, 0);
      chk("len0_done1",   o_d1, 2);
      chk("len0_en_cnt",  o_en, 0);
      chk("len0_clr_cnt", o_clr, 1);

      align();
      req0 = 1'b1; len0 = 4'd9;
      req1 = 1'b1; len1 = 4'd1;
      obs(12, 4);
      chk("abort_g0_rise", o_g0r, 0);
      chk("abort_g0_fall", o_g0f, 6);
      chk("abort_no_done", o_d0, -1);
      chk("abort_qmax",    o_qmax, 4);
      chk("abort_g1_rise", o_g1r, 7);
      chk("abort_done1",   o_d1, 10);

      align();
      req0 = 1'b1; len0 = 4'd15;
      obs(20, -1);
      chk("max_g0_rise", o_g0r, 0);
      chk("max_done0",   o_d0, 17);
      chk("max_q_done",  o_qdone, 15);
      chk("max_qmax",    o_qmax, 15);
      chk("max_en_cnt",  o_en, 15);

      align();
      req0 = 1'b1; len0 = 4'd15;
      repeat (6) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("arst_gnt0", int'(gnt0), 0);
      chk("arst_en",   int'(cnt_en), 0);
      chk("arst_busy", int'(busy), 0);
      req0 = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
